// File: rtl/i2c_init_sequencer_pkg.sv
// Shared definitions for the sensor power-on register-write sequencer:
// state encoding, configuration table entry layout and default device address.
package i2c_init_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_SETTLE = 3'd4,
    S_RETRY  = 3'd5,
    S_DONE   = 3'd6,
    S_FAIL   = 3'd7
  } state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } entry_t;

  localparam logic [6:0] DEFAULT_DEV_ADDRESS = 7'h21;

endpackage

// File: rtl/sensor_init_rom.sv
// Power-on configuration table for the sensor: index -> {reg_address, data}.
// Swap this file to retarget the sequencer to a different sensor.
module sensor_init_rom
  import i2c_init_sequencer_pkg::*;
(
  input  logic [3:0] i_index,
  output entry_t     o_entry
);

  always_comb begin
    o_entry = '0;
    case (i_index)
      4'd0:  o_entry = {8'h12, 8'h80};  // soft reset first
      4'd1:  o_entry = {8'h11, 8'h01};
      4'd2:  o_entry = {8'h0C, 8'h0A};
      4'd3:  o_entry = {8'h3A, 8'h04};
      4'd4:  o_entry = {8'h40, 8'hC0};
      4'd5:  o_entry = {8'h8C, 8'h00};
      4'd6:  o_entry = {8'h13, 8'hE7};
      4'd7:  o_entry = {8'h6B, 8'h4A};
      4'd8:  o_entry = {8'h3D, 8'hC0};
      4'd9:  o_entry = {8'h14, 8'h18};
      4'd10: o_entry = {8'h4F, 8'hB3};
      4'd11: o_entry = {8'h50, 8'hB3};
      4'd12: o_entry = {8'h51, 8'h00};
      4'd13: o_entry = {8'h52, 8'h3D};
      4'd14: o_entry = {8'h53, 8'hA7};
      4'd15: o_entry = {8'h54, 8'hE4};
      default: o_entry = '0;
    endcase
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Drives the I2C register-write FSM through the sensor power-on table, with
// per-entry retries, a write timeout and a settle gap after every good write.
module i2c_init_sequencer
  import i2c_init_sequencer_pkg::*;
#(
  parameter int         NUM_ENTRIES   = 8,
  parameter logic [6:0] DEV_ADDRESS   = DEFAULT_DEV_ADDRESS,
  parameter int         MAX_RETRIES   = 3,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         WAIT_TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  output logic       init_done,
  output logic       init_failed,
  output logic       busy,
  output logic [6:0] write_dev_address,
  output logic [7:0] write_reg_address,
  output logic [7:0] write_data,
  output logic       write_start,
  input  logic       write_done,
  input  logic       write_failure,
  output logic [3:0] entry_index,
  output logic [2:0] retry_count,
  output logic [2:0] state_out
);

  localparam logic [3:0]  ENTRY_LAST  = 4'(NUM_ENTRIES - 1);
  localparam logic [2:0]  RETRY_LAST  = 3'(MAX_RETRIES);
  localparam logic [15:0] TMO_LAST    = 16'(WAIT_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_entry_index;
  logic [2:0]  r_retry_count;
  logic [15:0] r_timeout_cnt;
  logic [15:0] r_settle_cnt;
  logic [7:0]  r_reg_addr;
  logic [7:0]  r_data;
  logic        r_init_failed;
  entry_t      w_entry;
  logic        w_tmo_expired;
  logic        w_settle_expired;

  sensor_init_rom u_rom (
    .i_index (r_entry_index),
    .o_entry (w_entry)
  );

  // The timeout fires on the edge where the counter would reach its limit.
  assign w_tmo_expired    = ({1'b0, r_timeout_cnt} + 17'd1) >= {1'b0, TMO_LAST};
  assign w_settle_expired = r_settle_cnt >= SETTLE_LAST;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (init_start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_START;
      S_START:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (write_done)                          w_state_nxt = S_SETTLE;
        else if (write_failure || w_tmo_expired) w_state_nxt = S_RETRY;
      end
      S_SETTLE: begin
        if (w_settle_expired)
          w_state_nxt = (r_entry_index == ENTRY_LAST) ? S_DONE : S_LOAD;
      end
      S_RETRY:  w_state_nxt = (r_retry_count == RETRY_LAST) ? S_FAIL : S_START;
      S_DONE:   w_state_nxt = S_IDLE;
      S_FAIL:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_entry_index <= '0;
      r_retry_count <= '0;
      r_timeout_cnt <= '0;
      r_settle_cnt  <= '0;
      r_reg_addr    <= '0;
      r_data        <= '0;
      r_init_failed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (init_start) begin
            r_entry_index <= '0;
            r_retry_count <= '0;
            r_init_failed <= 1'b0;
          end
        end
        S_LOAD: begin
          r_reg_addr <= w_entry.reg_addr;
          r_data     <= w_entry.data;
        end
        S_START: r_timeout_cnt <= '0;
        S_WAIT: begin
          if (r_timeout_cnt != TMO_LAST) r_timeout_cnt <= r_timeout_cnt + 16'd1;
          if (write_done)                r_settle_cnt  <= '0;
        end
        S_SETTLE: begin
          if (w_settle_expired) begin
            if (r_entry_index != ENTRY_LAST) begin
              r_entry_index <= r_entry_index + 4'd1;
              r_retry_count <= '0;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        // Retry is a one-cycle gap so the write FSM can return to idle; the
        // latched entry is reused as-is.
        S_RETRY: begin
          if (r_retry_count == RETRY_LAST) r_init_failed <= 1'b1;
          else                             r_retry_count <= r_retry_count + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    write_start = (r_state == S_START);
    init_done   = (r_state == S_DONE);
  end

  assign init_failed       = r_init_failed;
  assign write_dev_address = DEV_ADDRESS;
  assign write_reg_address = r_reg_addr;
  assign write_data        = r_data;
  assign entry_index       = r_entry_index;
  assign retry_count       = r_retry_count;
  assign state_out         = r_state;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: a scripted write-FSM responder plus a
// transaction-level model predicting every write_start and the final outcome.
module tb_i2c_init_sequencer;

  localparam int N  = 3;
  localparam int MR = 3;
  localparam int SC = 20;
  localparam int WT = 50;
  localparam logic [6:0] DEV = 7'h21;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_start = 1'b0;
  logic       write_done = 1'b0;
  logic       write_failure = 1'b0;
  logic       init_done, init_failed, busy, write_start;
  logic [6:0] write_dev_address;
  logic [7:0] write_reg_address, write_data;
  logic [3:0] entry_index;
  logic [2:0] retry_count, state_out;

  i2c_init_sequencer #(
    .NUM_ENTRIES(N), .DEV_ADDRESS(DEV), .MAX_RETRIES(MR),
    .SETTLE_CYCLES(SC), .WAIT_TIMEOUT(WT)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .init_done(init_done), .init_failed(init_failed), .busy(busy),
    .write_dev_address(write_dev_address), .write_reg_address(write_reg_address),
    .write_data(write_data), .write_start(write_start),
    .write_done(write_done), .write_failure(write_failure),
    .entry_index(entry_index), .retry_count(retry_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  idx;
    logic [2:0]  rty;
    logic [7:0]  ra;
    logic [7:0]  dat;
    logic [31:0] cyc;
  } start_t;

  // Sensor table as documented for this device
  logic [15:0] tb_table [16] = '{16'h1280, 16'h1101, 16'h0C0A, 16'h3A04,
                                 16'h40C0, 16'h8C00, 16'h13E7, 16'h6B4A,
                                 16'h3DC0, 16'h1418, 16'h4FB3, 16'h50B3,
                                 16'h5100, 16'h523D, 16'h53A7, 16'h54E4};

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder kinds: 0 done, 1 failure, 2 both in one cycle, 3 silent
  int          plan_kind[$];
  int          plan_dly[$];
  start_t      obs_q[$];
  start_t      exp_q[$];
  logic [31:0] retry_q[$];
  bit          pend = 0;
  int          pend_kind = 0;
  logic [31:0] pend_due = 0;
  bit          prev_start = 0;
  bit          prev_retry = 0;
  int          done_cnt = 0;
  logic [31:0] done_cyc = 0;
  int          dbl_start = 0;
  int          dev_bad = 0;
  bit          seq_timeout = 0;
  bit          exp_ok = 0;
  int          exp_fail_idx = 0;
  logic [31:0] exp_done_cyc = 0;

  always @(negedge clk) begin
    write_done = 1'b0;
    write_failure = 1'b0;
    if (!reset) begin
      pend = 0;
      prev_start = 0;
      prev_retry = 0;
    end else begin
      if (pend && cyc == pend_due) begin
        pend = 0;
        if (pend_kind == 0 || pend_kind == 2) write_done = 1'b1;
        if (pend_kind == 1 || pend_kind == 2) write_failure = 1'b1;
      end
      if (write_start) begin
        if (prev_start) dbl_start++;
        if (write_dev_address !== DEV) dev_bad++;
        obs_q.push_back(start_t'{entry_index, retry_count, write_reg_address, write_data, cyc});
        if (plan_kind.size() > 0) begin
          pend_kind = plan_kind.pop_front();
          pend_due  = cyc + 32'(plan_dly.pop_front());
        end else begin
          pend_kind = 0;
          pend_due  = cyc + 32'd5;
        end
        pend = (pend_kind != 3);
      end
      prev_start = write_start;
      if (state_out == 3'd5 && !prev_retry) retry_q.push_back(cyc);
      prev_retry = (state_out == 3'd5);
      if (init_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic add(input int kind, input int d);
    plan_kind.push_back(kind);
    plan_dly.push_back(d);
  endtask

  task automatic clear_plan();
    plan_kind.delete();
    plan_dly.delete();
  endtask

  // Transaction-level prediction: which (entry, attempt) pairs get started,
  // in which cycle, and how the whole run ends.
  function automatic void build_expected(input logic [31:0] t0);
    logic [31:0] t;
    int k, kind, d;
    exp_q.delete();
    exp_ok = 0;
    exp_fail_idx = 0;
    exp_done_cyc = 0;
    t = t0 + 32'd2;
    k = 0;
    for (int e = 0; e < N; e++) begin
      for (int a = 0; a <= MR; a++) begin
        kind = (k < plan_kind.size()) ? plan_kind[k] : 0;
        d    = (k < plan_dly.size()) ? plan_dly[k] : 5;
        k++;
        exp_q.push_back(start_t'{4'(e), 3'(a), tb_table[e][15:8], tb_table[e][7:0], t});
        if (kind == 0 || kind == 2) begin
          if (e == N - 1) begin
            exp_ok = 1;
            exp_done_cyc = t + 32'(d + SC + 1);
            return;
          end
          t = t + 32'(d + SC + 2);
          break;
        end
        t = (kind == 3) ? t + 32'(WT + 1) : t + 32'(d + 2);
        if (a == MR) begin
          exp_fail_idx = e;
          return;
        end
      end
    end
  endfunction

  task automatic run_seq();
    logic [31:0] t0;
    @(negedge clk);
    t0 = cyc;
    build_expected(t0);
    obs_q.delete();
    retry_q.delete();
    done_cnt = 0;
    dbl_start = 0;
    dev_bad = 0;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    seq_timeout = 1;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin
        seq_timeout = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, write_start, init_done, init_failed, write_reg_address, write_data,
         entry_index, retry_count, state_out} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {busy, write_start, init_done, init_failed,
               write_reg_address, write_data, entry_index, retry_count, state_out});
    end
    checks++;
    if (write_dev_address !== DEV) begin
      errors++;
      $display("FAIL reset_dev_address: got %h required %h", write_dev_address, DEV);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_nominal();
    clear_plan();
    repeat (3) add(0, 5);
    run_seq();
    checks++;
    if (seq_timeout) begin errors++; $display("FAIL nominal_timeout: busy stuck got 1 required 0"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL nominal_starts: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL nominal_start%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (dev_bad != 0 || dbl_start != 0) begin
      errors++; $display("FAIL nominal_dev_or_pulse: got dev_bad=%0d dbl=%0d required 0 0", dev_bad, dbl_start);
    end
    checks++;
    if (done_cnt != 1 || done_cyc !== exp_done_cyc) begin
      errors++; $display("FAIL nominal_done: got cnt=%0d cyc=%0d required 1 %0d", done_cnt, done_cyc, exp_done_cyc);
    end
    checks++;
    if (init_failed !== 1'b0) begin errors++; $display("FAIL nominal_failed: got %b required 0", init_failed); end
  endtask

  task automatic test_single_retry();
    clear_plan();
    add(0, 5); add(1, 4); add(0, 5); add(0, 7);
    run_seq();
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL retry_starts: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL retry_start%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 4) begin
      checks++;
      if (obs_q[2].idx !== 4'd1 || obs_q[2].rty !== 3'd1 || {obs_q[2].ra, obs_q[2].dat} !== tb_table[1]) begin
        errors++; $display("FAIL retry_second_attempt: got %h required idx1 rty1 %h", obs_q[2], tb_table[1]);
      end
      checks++;
      if (obs_q[3].rty !== 3'd0) begin errors++; $display("FAIL retry_cleared: got %0d required 0", obs_q[3].rty); end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL retry_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_retry_exhaustion();
    int n2;
    clear_plan();
    add(0, 5); add(0, 5);
    repeat (4) add(1, int'($urandom_range(1, 30)));
    run_seq();
    n2 = 0;
    foreach (obs_q[i]) if (obs_q[i].idx == 4'd2) n2++;
    checks++;
    if (n2 != 4) begin errors++; $display("FAIL exhaust_entry2_starts: got %0d required 4", n2); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL exhaust_start%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({init_failed, entry_index, busy} !== {1'b1, 4'd2, 1'b0} || done_cnt != 0) begin
      errors++; $display("FAIL exhaust_end: got failed=%b idx=%0d busy=%b done=%0d required 1 2 0 0",
                         init_failed, entry_index, busy, done_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_plan();
    repeat (4) add(3, 0);
    run_seq();
    checks++;
    if (retry_q.size() < 1 || obs_q.size() < 1) begin
      errors++; $display("FAIL timeout_retry_seen: got %0d required >=1", retry_q.size());
    end else if (retry_q[0] - obs_q[0].cyc !== 32'(WT)) begin
      errors++; $display("FAIL timeout_latency: got %0d required %0d", retry_q[0] - obs_q[0].cyc, WT);
    end
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL timeout_starts: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL timeout_start%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (init_failed !== 1'b1 || entry_index !== 4'd0) begin
      errors++; $display("FAIL timeout_end: got failed=%b idx=%0d required 1 0", init_failed, entry_index);
    end
  endtask

  task automatic test_done_and_failure();
    checks++;
    if (init_failed !== 1'b1) begin errors++; $display("FAIL sticky_failed: got %b required 1", init_failed); end
    clear_plan();
    add(0, 5); add(2, 6); add(0, 5);
    run_seq();
    checks++;
    if (obs_q.size() != 3 || retry_q.size() != 0) begin
      errors++; $display("FAIL both_no_retry: got starts=%0d retries=%0d required 3 0", obs_q.size(), retry_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL both_start%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || init_failed !== 1'b0) begin
      errors++; $display("FAIL both_end: got done=%0d failed=%b required 1 0", done_cnt, init_failed);
    end
  endtask

  task automatic test_reset_mid_settle();
    bit found;
    clear_plan();
    repeat (3) add(0, 5);
    @(negedge clk);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (state_out == 3'd4 && entry_index == 4'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_reach_settle: got 0 required 1"); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, write_start, init_done, init_failed, write_reg_address, write_data,
         entry_index, retry_count, state_out} !== 30'd0 || write_dev_address !== DEV) begin
      errors++;
      $display("FAIL midreset_async: got %h dev=%h required 0 %h", {busy, write_start, init_done, init_failed,
               write_reg_address, write_data, entry_index, retry_count, state_out}, write_dev_address, DEV);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    clear_plan();
    repeat (3) add(0, 5);
    run_seq();
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL midreset_restart: got %0d starts first %h required %h",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : start_t'(0), exp_q[0]);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL midreset_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 6; it++) begin
      clear_plan();
      for (int j = 0; j < N * (MR + 1); j++) begin
        r = int'($urandom_range(0, 9));
        add((r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3, int'($urandom_range(1, 40)));
      end
      run_seq();
      checks++;
      if (seq_timeout || obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_starts: got %0d timeout=%b required %0d", it, obs_q.size(), seq_timeout, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_start%0d: got %h required %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (exp_ok ? (done_cnt != 1 || done_cyc !== exp_done_cyc || init_failed !== 1'b0 || entry_index !== 4'(N - 1))
                 : (done_cnt != 0 || init_failed !== 1'b1 || entry_index !== 4'(exp_fail_idx))) begin
        errors++;
        $display("FAIL rand%0d_outcome: got done=%0d@%0d failed=%b idx=%0d required ok=%b @%0d idx=%0d",
                 it, done_cnt, done_cyc, init_failed, entry_index, exp_ok, exp_done_cyc,
                 exp_ok ? N - 1 : exp_fail_idx);
      end
      checks++;
      if (dbl_start != 0 || dev_bad != 0) begin
        errors++; $display("FAIL rand%0d_pulse: got dbl=%0d dev_bad=%0d required 0 0", it, dbl_start, dev_bad);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_single_retry();
    test_retry_exhaustion();
    test_timeout();
    test_done_and_failure();
    test_reset_mid_settle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
Sits directly upstream of the I2C register-write FSM and drives it through a fixed power-on configuration table of (reg_address, data) pairs for one sensor device. On init_start it issues one register write per table entry, waits for done or message_failure, and retries a failed entry up to MAX_RETRIES times. Between writes it waits a programmable settle interval. It reports overall completion or failure to the sensor-module top level.

Parameters:
NUM_ENTRIES, 8, number of valid table entries (1..16)
DEV_ADDRESS, 7'h21, 7-bit I2C device address applied to every write
MAX_RETRIES, 3, extra attempts per entry after the first failure (0..7)
SETTLE_CYCLES, 1000, idle clk cycles after each successful write (>=1)
WAIT_TIMEOUT, 65535, clk cycles allowed in S_WAIT before a write counts as failed

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset; clears every register immediately
init_start  in  1  level or pulse; sampled only in S_IDLE
init_done  out  1  one-cycle pulse when all entries are written
init_failed  out  1  sticky; set on abort, cleared by the next accepted init_start or by reset
busy  out  1  high in every state except S_IDLE
write_dev_address  out  7  to write FSM dev_address; constant DEV_ADDRESS
write_reg_address  out  8  to write FSM reg_address; registered
write_data  out  8  to write FSM data; registered
write_start  out  1  one-cycle start pulse to write FSM
write_done  in  1  done pulse from write FSM
write_failure  in  1  message_failure pulse from write FSM
entry_index  out  4  current table index (debug)
retry_count  out  3  attempts used on current entry (debug)
state_out  out  3  current state encoding (debug)

Behaviour:
- Reset values: all outputs 0, except write_dev_address = DEV_ADDRESS. State = S_IDLE; internal counters = 0.
- State encoding: S_IDLE=0, S_LOAD=1, S_START=2, S_WAIT=3, S_SETTLE=4, S_RETRY=5, S_DONE=6, S_FAIL=7.
- S_IDLE: if init_start, go to S_LOAD; clear entry_index, retry_count and init_failed.
- S_LOAD: latch table[entry_index] into write_reg_address and write_data. Go to S_START.
  - Outputs stay stable from this point until the entry leaves S_WAIT.
- S_START: assert write_start for exactly this one cycle. Clear the timeout counter. Go to S_WAIT.
- S_WAIT: increment the timeout counter.
  - write_done: go to S_SETTLE, clear the settle counter. write_done has priority if both pulses arrive in the same cycle.
  - write_failure, or timeout counter reaching WAIT_TIMEOUT-1: go to S_RETRY.
- S_SETTLE: count SETTLE_CYCLES cycles.
  - On expiry, if entry_index == NUM_ENTRIES-1, go to S_DONE.
  - Otherwise increment entry_index, clear retry_count, go to S_LOAD.
- S_RETRY: if retry_count == MAX_RETRIES, go to S_FAIL. Otherwise increment retry_count, wait 1 cycle, go to S_START.
  - The 1-cycle wait lets the write FSM return to its reset state; the entry is not reloaded.
- S_DONE: pulse init_done for one cycle, go to S_IDLE.
- S_FAIL: set init_failed, go to S_IDLE. entry_index keeps the failing index until the next start.
- Ignored inputs:
  - init_start is ignored outside S_IDLE.
  - write_done and write_failure are ignored outside S_WAIT.
- Latency: init_start to first write_start = 3 cycles (S_IDLE, S_LOAD, S_START).
- Reset asserted mid-sequence: abort immediately, write_start drops to 0, no done/failed pulse. The write FSM is reset by the same top-level reset.
- Counters:
  - Timeout and settle counters are 16 bits and saturate at their limit.
  - entry_index never exceeds NUM_ENTRIES-1.
- The write FSM's start input is level-sensitive, so write_start must never be high for more than one cycle.

Decomposition:
- Shared package: state encodings; the table entry layout {reg[7:0], data[7:0]}; the default DEV_ADDRESS.
- Sub-module sensor_init_rom: combinational case statement, 4-bit index to 16-bit entry. This keeps table content separate from the sequencing logic so the table can be swapped per sensor.

Test Plan:
- Nominal: NUM_ENTRIES=3, write model returns write_done 5 cycles after each start. Pulse init_start. Expect:
  - 3 write_start pulses carrying table[0..2]; write_dev_address = 7'h21 throughout;
  - init_done pulse SETTLE_CYCLES+1 cycles after the third write_done; init_failed = 0.
- Single retry: write_failure on the first attempt of entry 1, then write_done. Expect:
  - entry 1 started twice with the same reg/data; retry_count=1 during the second attempt, reset to 0 at entry 2;
  - init_done asserted.
- Retry exhaustion: MAX_RETRIES=3, entry 2 always fails. Expect exactly 4 write_start pulses on entry 2, then init_failed=1, entry_index=2, busy=0, no init_done.
- Timeout: WAIT_TIMEOUT=50, write model silent. Expect S_RETRY entered 50 cycles after write_start. After 4 attempts, init_failed=1.
- Simultaneous write_done and write_failure in the same cycle: expect S_SETTLE (done wins), no retry.
- Reset mid-S_SETTLE of entry 1: expect all outputs at reset values in the same cycle (asynchronous). A later init_start restarts from entry 0.
